// File: rtl/gaussian_blur_frame_ctrl.sv
// rtl/gaussian_blur_frame_ctrl.sv - raster frame sequencer feeding the 3x3 Gaussian blur core
// Builds one 3x3 window per interior pixel with column reuse and tags each result with its address.
module gaussian_blur_frame_ctrl #(
  parameter int IMG_W    = 128,
  parameter int IMG_H    = 128,
  parameter int ADDR_W   = 14,
  parameter int CORE_LAT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic [71:0]       win_px,
  output logic              win_vld,
  input  logic [7:0]        core_out,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, FIRE, FLUSH, DONE} state_t;
  state_t state, state_nxt;

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [1:0]    col_off, row_off;
  logic [3:0]    slot, cap_slot;
  logic          cap_vld;
  logic [8:0][7:0] win;
  logic [CORE_LAT-1:0]             tag_vld;
  logic [CORE_LAT-1:0][ADDR_W-1:0] tag_addr;
  logic          last_rd, row_end, frame_end, tags_pending;
  logic [ADDR_W-1:0] rd_row, rd_col;

  assign last_rd   = (col_off == 2'd2) && (row_off == 2'd2);
  assign row_end   = (x == XW'(IMG_W - 2));
  assign frame_end = (y == YW'(IMG_H - 2));
  assign slot      = 4'(row_off) * 4'd3 + 4'(col_off);
  assign rd_row    = ADDR_W'(y) + ADDR_W'(row_off) - ADDR_W'(1);
  assign rd_col    = ADDR_W'(x) + ADDR_W'(col_off) - ADDR_W'(1);

  // The last tag stage is the write in progress; FLUSH only waits on the younger ones.
  always_comb begin
    tags_pending = 1'b0;
    for (int i = 0; i < CORE_LAT - 1; i++) tags_pending = tags_pending | tag_vld[i];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FETCH;
      FETCH:   if (last_rd) state_nxt = DRAIN;
      DRAIN:   state_nxt = FIRE;
      FIRE:    state_nxt = (row_end && frame_end) ? FLUSH : FETCH;
      FLUSH:   if (!tags_pending) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x        <= XW'(1);
      y        <= YW'(1);
      col_off  <= 2'd0;
      row_off  <= 2'd0;
      cap_vld  <= 1'b0;
      cap_slot <= 4'd0;
      win      <= '0;
      tag_vld  <= '0;
      tag_addr <= '0;
    end else begin
      cap_vld  <= (state == FETCH);
      cap_slot <= slot;
      for (int i = CORE_LAT - 1; i > 0; i--) begin
        tag_vld[i]  <= tag_vld[i-1];
        tag_addr[i] <= tag_addr[i-1];
      end
      tag_vld[0]  <= (state == FIRE);
      tag_addr[0] <= ADDR_W'(y) * ADDR_W'(IMG_W) + ADDR_W'(x);
      case (state)
        IDLE: if (start) begin
          x       <= XW'(1);
          y       <= YW'(1);
          col_off <= 2'd0;
          row_off <= 2'd0;
        end
        FETCH: begin
          if (row_off == 2'd2) begin
            row_off <= 2'd0;
            col_off <= col_off + 2'd1;
          end else begin
            row_off <= row_off + 2'd1;
          end
        end
        FIRE: begin
          row_off <= 2'd0;
          if (!row_end) begin
            // Slide the window; the next FETCH only refills the right column.
            x       <= x + XW'(1);
            col_off <= 2'd2;
            for (int r = 0; r < 3; r++) begin
              win[r*3]   <= win[r*3+1];
              win[r*3+1] <= win[r*3+2];
            end
          end else begin
            x       <= XW'(1);
            col_off <= 2'd0;
            if (!frame_end) y <= y + YW'(1);
          end
        end
        default: ;
      endcase
      if (cap_vld) win[cap_slot] <= rd_data;
    end
  end

  assign busy    = (state == FETCH) || (state == DRAIN) || (state == FIRE) || (state == FLUSH);
  assign done    = (state == DONE);
  assign rd_en   = (state == FETCH);
  assign rd_addr = rd_en ? (rd_row * ADDR_W'(IMG_W) + rd_col) : '0;
  assign win_vld = (state == FIRE);
  assign win_px  = win;
  assign wr_en   = tag_vld[CORE_LAT-1];
  assign wr_addr = tag_addr[CORE_LAT-1];
  assign wr_data = core_out;
endmodule
